// File: rtl/sm_result_restore.sv
// Bit-serial restore of a minuend from a sign-magnitude difference: A = neg ? B - MAG : B + MAG.
// One bit per clock, LSB first; flags differences that no valid subtract could have produced.
module sm_result_restore #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] mag,
    input  logic             neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] b_sr, m_sr, res_sr;
    logic             neg_r, mag_zero, c, err_r;
    logic [CW-1:0]    cnt;

    logic bi, mi, s, cn;

    // One full adder/subtractor slice; c is carry for add, borrow for subtract.
    always_comb begin
        bi = b_sr[0];
        mi = m_sr[0];
        s  = bi ^ mi ^ c;
        if (neg_r) cn = (~bi & mi) | (~(bi ^ mi) & c);
        else       cn = (bi & mi) | (bi & c) | (mi & c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            b_sr     <= '0;
            m_sr     <= '0;
            res_sr   <= '0;
            neg_r    <= 1'b0;
            mag_zero <= 1'b0;
            c        <= 1'b0;
            err_r    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    b_sr     <= base;
                    m_sr     <= mag;
                    neg_r    <= neg;
                    mag_zero <= (mag == '0);
                    c        <= 1'b0;
                    cnt      <= '0;
                    err_r    <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    res_sr <= {s, res_sr[WIDTH-1:1]};
                    b_sr   <= b_sr >> 1;
                    m_sr   <= m_sr >> 1;
                    c      <= cn;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // A zero magnitude tagged negative cannot come out of the subtract path.
                        err_r <= neg_r ? (cn | mag_zero) : cn;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_sr;
    assign err       = err_r;

endmodule
